// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// instruction word width, PC step and the default reset address.
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam int          INSTR_WIDTH      = 32;
  localparam logic [31:0] PC_INCR          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry instruction/PC FIFO sitting between the memory response and
// decode. valid/ready on both sides, synchronous flush for redirects.
module fetch_buffer
  import instruction_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_WIDTH-1:0] in_data,
  input  logic [31:0]            in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_data,
  output logic [31:0]            out_pc,
  output logic [1:0]             count
);

  logic [INSTR_WIDTH-1:0] data_q [2];
  logic [31:0]            pc_q   [2];
  logic                   rd_ptr_q;
  logic                   wr_ptr_q;
  logic [1:0]             count_q;
  logic                   push;
  logic                   pop;

  assign in_ready  = (count_q != 2'(DEPTH));
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = data_q[rd_ptr_q];
  assign out_pc    = pc_q[rd_ptr_q];
  assign count     = count_q;

  // Storage, pointers and occupancy; flush empties the queue but leaves the
  // stale words in place since nothing reads them until they are rewritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        data_q[wr_ptr_q] <= in_data;
        pc_q[wr_ptr_q]   <= in_pc;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: sequential PC generation, one-cycle-latency memory
// interface, two-entry output buffer with a same-cycle bypass so a returning
// word reaches decode with no bubble, redirect with epoch-based discard of
// in-flight responses, and halt.
// Optional feature: define IFETCH_PERF_EN to get a delivered-instruction
// counter on fetch_count; otherwise fetch_count is tied to zero.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req,
  output logic [31:0]            imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_target,
  input  logic                   halt,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [31:0]            instr_pc,
  output logic [31:0]            instr_pc4,
  output logic [31:0]            fetch_count
);

  fetch_state_t           state_q;
  logic [31:0]            pc_q;
  logic                   epoch_q;
  logic                   inflight_q;
  logic                   inflight_epoch_q;
  logic [31:0]            inflight_pc_q;

  logic                   transfer;
  logic [2:0]             occupancy;
  logic                   bypass_valid;
  logic                   use_bypass;
  logic                   fifo_push;
  logic                   fifo_in_ready;
  logic                   fifo_out_valid;
  logic [INSTR_WIDTH-1:0] fifo_data;
  logic [31:0]            fifo_pc;
  logic [1:0]             fifo_count;
  logic                   unused_target_bits;

  assign unused_target_bits = ^redirect_target[1:0];

  assign transfer = instr_valid & instr_ready;

  // Entries that will be occupied once everything already requested has
  // landed, crediting the entry decode is taking this cycle.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, transfer};

  assign imem_req  = (state_q == RUN) && !redirect_valid && !halt &&
                     (occupancy < 3'(BUF_DEPTH));
  assign imem_addr = pc_q;

  // A response is usable only if it belongs to the current epoch and no
  // redirect is discarding it in this very cycle.
  assign bypass_valid = inflight_q && (inflight_epoch_q == epoch_q) && !redirect_valid;
  assign use_bypass   = bypass_valid && !fifo_out_valid;
  assign fifo_push    = bypass_valid && fifo_in_ready && !(use_bypass && instr_ready);

  assign instr_valid = fifo_out_valid || bypass_valid;
  assign instruction = use_bypass ? imem_rdata    : fifo_data;
  assign instr_pc    = use_bypass ? inflight_pc_q : fifo_pc;
  assign instr_pc4   = instr_pc + PC_INCR;

  fetch_buffer #(
    .DEPTH(BUF_DEPTH)
  ) u_fetch_buffer (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_valid),
    .in_valid (fifo_push),
    .in_ready (fifo_in_ready),
    .in_data  (imem_rdata),
    .in_pc    (inflight_pc_q),
    .out_valid(fifo_out_valid),
    .out_ready(instr_ready),
    .out_data (fifo_data),
    .out_pc   (fifo_pc),
    .count    (fifo_count)
  );

  // Fetch FSM with PC, epoch and in-flight tracking; redirect overrides both
  // sequential stepping and halt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= BOOT;
      pc_q             <= {RESET_PC[31:2], 2'b00};
      epoch_q          <= 1'b0;
      inflight_q       <= 1'b0;
      inflight_epoch_q <= 1'b0;
      inflight_pc_q    <= '0;
    end else begin
      inflight_q       <= imem_req;
      inflight_epoch_q <= epoch_q;
      if (imem_req) begin
        inflight_pc_q <= pc_q;
      end
      if (redirect_valid) begin
        epoch_q <= ~epoch_q;
        pc_q    <= {redirect_target[31:2], 2'b00};
        state_q <= RUN;
      end else begin
        if (imem_req) begin
          pc_q <= pc_q + PC_INCR;
        end
        case (state_q)
          BOOT:    state_q <= RUN;
          RUN:     state_q <= halt ? HALTED : RUN;
          HALTED:  state_q <= HALTED;
          default: state_q <= BOOT;
        endcase
      end
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_count_q;

  // Count every handshake with decode, wrapping naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_q <= '0;
    end else if (transfer) begin
      fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  assign fetch_count = fetch_count_q;
`else
  assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch: reset values, streaming fetch,
// backpressure, reset mid-fetch, redirect with in-flight discard, halt/resume
// and PC wrap. Memory returns the word index {2'b00, addr[31:2]}.
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc4;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;
  int req_seen;
  logic [31:0] exp_count;

  instruction_fetch #(
    .RESET_PC (32'h0000_0000),
    .BUF_DEPTH(2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .halt           (halt),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instruction    (instruction),
    .instr_pc       (instr_pc),
    .instr_pc4      (instr_pc4),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency memory: word index of the requested address.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= {2'b00, imem_addr[31:2]};
    else          imem_rdata <= 32'hDEAD_BEEF;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic redir, input logic [31:0] target,
                               input logic hlt, input logic rdy);
    @(posedge clk);
    #1;
    redirect_valid  = redir;
    redirect_target = target;
    halt            = hlt;
    instr_ready     = rdy;
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    halt            = 1'b0;
    instr_ready     = 1'b0;
    imem_rdata      = 32'h0;
`ifdef IFETCH_PERF_EN
    exp_count = 32'd10;
`else
    exp_count = 32'd0;
`endif

    repeat (2) @(posedge clk);
    #2;
    checkOutput("rst_req",    32'(imem_req),    32'h0);
    checkOutput("rst_valid",  32'(instr_valid), 32'h0);
    checkOutput("rst_instr",  instruction,      32'h0);
    checkOutput("rst_pc",     instr_pc,         32'h0);
    checkOutput("rst_pc4",    instr_pc4,        32'h4);
    checkOutput("rst_count",  fetch_count,      32'h0);

    // Release reset: BOOT cycle, then streaming with decode always ready.
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    instr_ready = 1'b1;
    #1;
    checkOutput("boot_req", 32'(imem_req), 32'h0);

    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("first_req",   32'(imem_req),    32'h1);
    checkOutput("first_addr",  imem_addr,        32'h0);
    checkOutput("first_valid", 32'(instr_valid), 32'h0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("stream_valid", 32'(instr_valid), 32'h1);
      checkOutput("stream_pc",    instr_pc,         32'(4 * i));
      checkOutput("stream_instr", instruction,      32'(i));
      checkOutput("stream_pc4",   instr_pc4,        32'(4 * i + 4));
      checkOutput("stream_addr",  imem_addr,        32'(4 * (i + 1)));
    end

    // Decode stalls; exactly ten transfers have happened so far.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("perf_count", fetch_count, exp_count);
    checkOutput("stall_pc",   instr_pc,    32'h28);

    // Reset pulse while the response for pc 0x2C is on imem_rdata.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_req",   32'(imem_req),    32'h0);
    checkOutput("midrst_valid", 32'(instr_valid), 32'h0);
    checkOutput("midrst_instr", instruction,      32'h0);
    checkOutput("midrst_pc4",   instr_pc4,        32'h4);
    checkOutput("midrst_count", fetch_count,      32'h0);
    rst_n = 1'b1;
    #1;
    checkOutput("reboot_valid", 32'(instr_valid), 32'h0);
    checkOutput("reboot_req",   32'(imem_req),    32'h0);

    // Five stalled cycles: two requests fill the buffer, head holds pc 0.
    req_seen = 0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      if (imem_req) req_seen++;
      if (k == 0) checkOutput("rereq_addr", imem_addr, 32'h0);
      if (k >= 2) begin
        checkOutput("hold_valid", 32'(instr_valid), 32'h1);
        checkOutput("hold_pc",    instr_pc,         32'h0);
        checkOutput("hold_req",   32'(imem_req),    32'h0);
      end
    end
    checkOutput("req_count", 32'(req_seen), 32'h2);

    for (int j = 0; j < 3; j++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("drain_valid", 32'(instr_valid), 32'h1);
      checkOutput("drain_pc",    instr_pc,         32'(4 * j));
    end

    // Redirect with pc 0xC at the head and pc 0x10 returning.
    applyStimulus(1'b1, 32'h0000_0103, 1'b0, 1'b1);
    checkOutput("redir_req",   32'(imem_req),    32'h0);
    checkOutput("redir_valid", 32'(instr_valid), 32'h1);
    checkOutput("redir_pc",    instr_pc,         32'hC);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("post_redir_valid", 32'(instr_valid), 32'h0);
    checkOutput("post_redir_req",   32'(imem_req),    32'h1);
    checkOutput("post_redir_addr",  imem_addr,        32'h100);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("target_valid", 32'(instr_valid), 32'h1);
    checkOutput("target_pc",    instr_pc,         32'h100);
    checkOutput("target_instr", instruction,      32'h40);

    // Halt with two buffered entries; they still drain, no new requests.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("halt_req",  32'(imem_req), 32'h0);
    checkOutput("halt_pc",   instr_pc,      32'h100);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("halt_drain0_req", 32'(imem_req), 32'h0);
    checkOutput("halt_drain0_pc",  instr_pc,      32'h100);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("halt_drain1_req",   32'(imem_req),    32'h0);
    checkOutput("halt_drain1_valid", 32'(instr_valid), 32'h1);
    checkOutput("halt_drain1_pc",    instr_pc,         32'h104);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("halt_empty_valid", 32'(instr_valid), 32'h0);
    checkOutput("halt_empty_req",   32'(imem_req),    32'h0);

    // Redirect together with halt: redirect wins and fetch resumes.
    applyStimulus(1'b1, 32'h0000_0040, 1'b1, 1'b1);
    checkOutput("resume_redir_req", 32'(imem_req), 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("resume_req",  32'(imem_req), 32'h1);
    checkOutput("resume_addr", imem_addr,     32'h40);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("resume_pc",    instr_pc,    32'h40);
    checkOutput("resume_instr", instruction, 32'h10);

    // PC wrap at the top of the address space.
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
    checkOutput("wrap_redir_req", 32'(imem_req), 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("wrap_addr_hi", imem_addr,        32'hFFFF_FFFC);
    checkOutput("wrap_valid0",  32'(instr_valid), 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("wrap_pc",      instr_pc,    32'hFFFF_FFFC);
    checkOutput("wrap_pc4",     instr_pc4,   32'h0);
    checkOutput("wrap_instr",   instruction, 32'h3FFF_FFFF);
    checkOutput("wrap_addr_lo", imem_addr,   32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("wrap_next_pc",    instr_pc,    32'h0);
    checkOutput("wrap_next_instr", instruction, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
